// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the banked byte-enable data RAM.
// Derived widths are computed from the top-level generics via these helpers.
package ram_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int bank_bits(input int bc);
    return clog2(bc);
  endfunction

  function automatic int local_width(input int aw, input int bc);
    return aw - clog2(bc);
  endfunction

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: byte-lane write, registered read.
// The array itself carries no reset; only the read register does.
module ram_bank #(
  parameter int LOCAL_WIDTH = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 4
) (
  input  logic                   CLK,
  input  logic                   Rst,
  input  logic                   en,
  input  logic                   we,
  input  logic [LANES-1:0]       be,
  input  logic [LOCAL_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  output logic [DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [2**LOCAL_WIDTH];

  always_ff @(posedge CLK) begin
    if (en && we) begin
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_banked_be.sv
// Banked single-port data RAM with byte enables, registered read
// and a row-sequenced clear engine that wipes all banks in parallel.
module ram_banked_be
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_COUNT = 4,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                    CLK,
  input  logic                    Rst,
  input  logic                    Req,
  input  logic                    We,
  input  logic [ADDR_WIDTH-1:0]   Addr,
  input  logic [DATA_WIDTH/8-1:0] BE,
  input  logic [DATA_WIDTH-1:0]   WData,
  input  logic                    Clr,
  output logic                    Ready,
  output logic                    RValid,
  output logic [DATA_WIDTH-1:0]   RData
);

  localparam int BANK_BITS   = bank_bits(BANK_COUNT);
  localparam int LOCAL_WIDTH = local_width(ADDR_WIDTH, BANK_COUNT);
  localparam int LANES       = lanes(DATA_WIDTH);
  localparam int SEL_W       = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam logic [LOCAL_WIDTH-1:0] LAST = '1;

  state_t state_q, state_d;
  logic [LOCAL_WIDTH-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]       bank, sel_q;
  logic [LOCAL_WIDTH-1:0] local_addr;
  logic                   clearing, acc, rd_acc;

  logic [BANK_COUNT-1:0]  bank_en;
  logic                   b_we;
  logic [LANES-1:0]       b_be;
  logic [LOCAL_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0]  b_wdata;
  logic [DATA_WIDTH-1:0]  rdata [BANK_COUNT];

  generate
    if (BANK_BITS > 0) begin : g_sel
      assign bank = Addr[ADDR_WIDTH-1 -: BANK_BITS];
    end else begin : g_nosel
      assign bank = '0;
    end
  endgenerate

  assign local_addr = Addr[LOCAL_WIDTH-1:0];
  assign clearing   = (state_q == CLEAR);
  assign Ready      = (state_q == IDLE) && !Clr;
  assign acc        = Req && Ready;
  assign rd_acc     = acc && !We;

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state_q <= INIT_CLEAR ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (Clr) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear rows hit every bank at once; normal accesses are one-hot.
  always_comb begin
    bank_en = '0;
    for (int b = 0; b < BANK_COUNT; b++)
      bank_en[b] = clearing || (acc && (bank == SEL_W'(b)));
  end

  assign b_we    = clearing || We;
  assign b_be    = clearing ? '1 : BE;
  assign b_addr  = clearing ? cnt_q : local_addr;
  assign b_wdata = clearing ? '0 : WData;

  for (genvar g = 0; g < BANK_COUNT; g++) begin : g_bank
    ram_bank #(
      .LOCAL_WIDTH(LOCAL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
    ) u_bank (
      .CLK  (CLK),
      .Rst  (Rst),
      .en   (bank_en[g]),
      .we   (b_we),
      .be   (b_be),
      .addr (b_addr),
      .wdata(b_wdata),
      .rdata(rdata[g])
    );
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      sel_q  <= '0;
      RValid <= 1'b0;
    end else begin
      RValid <= rd_acc;
      if (rd_acc) sel_q <= bank;
    end
  end

  // Bank read registers hold between reads, so RData holds too.
  assign RData = rdata[sel_q];

endmodule

// File: tb/tb_ram_banked_be.sv
// Randomised bench for ram_banked_be against a word-array model,
// plus a small-geometry instance for the short initial clear.
module tb_ram_banked_be;

  localparam int N = 1024;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0, we = 1'b0, clr = 1'b0;
  logic [11:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        ready, rvalid;
  logic [31:0] rdata;

  logic        s_rst = 1'b1;
  logic        s_req = 1'b0, s_we = 1'b0, s_clr = 1'b0;
  logic [3:0]  s_addr = '0;
  logic [3:0]  s_be = '0;
  logic [31:0] s_wd = '0;
  logic        s_ready, s_rvalid;
  logic [31:0] s_rdata;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  logic [31:0] mem [4096];
  int          clear_left = N;
  logic        erv = 1'b0;
  logic [31:0] erd = '0;

  always #5 CLK = ~CLK;

  ram_banked_be u_dut (
    .CLK(CLK), .Rst(rst_n), .Req(req), .We(we), .Addr(addr),
    .BE(be), .WData(wdata), .Clr(clr),
    .Ready(ready), .RValid(rvalid), .RData(rdata)
  );

  ram_banked_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BANK_COUNT(4), .INIT_CLEAR(1'b1)
  ) u_small (
    .CLK(CLK), .Rst(s_rst), .Req(s_req), .We(s_we), .Addr(s_addr),
    .BE(s_be), .WData(s_wd), .Clr(s_clr),
    .Ready(s_ready), .RValid(s_rvalid), .RData(s_rdata)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Model: clear is a busy window of N cycles that leaves memory zeroed.
  always @(posedge CLK) begin
    if (!rst_n) begin
      clear_left = N;
      erv = 1'b0;
      erd = '0;
    end else if (clear_left > 0) begin
      if (clear_left == 1)
        for (int i = 0; i < 4096; i++) mem[i] = '0;
      clear_left--;
      erv = 1'b0;
    end else if (clr) begin
      clear_left = N;
      erv = 1'b0;
    end else if (req && we) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[addr][l*8 +: 8] = wdata[l*8 +: 8];
      erv = 1'b0;
    end else if (req) begin
      erv = 1'b1;
      erd = mem[addr];
    end else begin
      erv = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      if (!rst_n) begin
        chk("rst_ready", ready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
      end else begin
        chk("ready", ready, (clear_left == 0) && !clr);
        chk("rvalid", rvalid, erv);
        chk("rdata", rdata, erd);
      end
    end
  end

  task automatic drive(input logic rq, input logic w,
                       input logic [11:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic c);
    req = rq; we = w; addr = a; be = b; wdata = d; clr = c;
    @(posedge CLK);
    #2;
    req = 1'b0; we = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 3000) begin
      @(posedge CLK);
      #2;
      n++;
    end
  endtask

  task automatic rand_phase(input int cycles);
    logic [11:0] a;
    logic        c, rq, w;
    for (int k = 0; k < cycles; k++) begin
      a[11:10] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        a[9:0] = 10'h3FF - 10'($urandom_range(0, 3));
      else
        a[9:0] = 10'($urandom_range(0, 7));
      c  = ($urandom_range(0, 999) == 0);
      rq = ($urandom_range(0, 9) < 7);
      w  = 1'($urandom_range(0, 1));
      drive(rq, w, a, 4'($urandom), $urandom, c);
    end
  endtask

  int n;

  initial begin
    #1;
    rst_n = 1'b0;
    s_rst = 1'b0;
    #2;
    chk_on = 1'b1;

    @(posedge CLK);
    #2;
    s_rst = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(posedge CLK);
      #2;
      n++;
    end
    chk("small_ready_low", n, 4);
    s_req = 1'b1; s_we = 1'b0; s_addr = 4'hF;
    @(posedge CLK);
    #2;
    s_req = 1'b0;
    chk("small_rvalid", s_rvalid, 1);
    chk("small_rdata", s_rdata, 32'h0);
    @(posedge CLK);
    #2;
    chk("small_rvalid_pulse", s_rvalid, 0);

    rst_n = 1'b1;
    wait_ready(n);
    chk("init_clear_len", n, N);

    drive(1, 1, 12'h005, 4'b1111, 32'hDEADBEEF, 0);
    drive(1, 0, 12'h005, 4'b0000, 32'h0, 0);
    chk("rd_full_v", rvalid, 1);
    chk("rd_full", rdata, 32'hDEADBEEF);
    drive(0, 0, 12'h0, 4'b0, 32'h0, 0);
    chk("rv_pulse", rvalid, 0);
    drive(1, 1, 12'h005, 4'b0010, 32'h0000AA00, 0);
    drive(1, 0, 12'h005, 4'b0000, 32'h0, 0);
    chk("rd_lane1", rdata, 32'hDEADAAEF);
    drive(1, 1, 12'h005, 4'b0000, 32'hFFFFFFFF, 0);
    drive(1, 0, 12'h005, 4'b0000, 32'h0, 0);
    chk("rd_be0", rdata, 32'hDEADAAEF);

    drive(1, 1, 12'h3FF, 4'hF, 32'h11111111, 0);
    drive(1, 1, 12'h400, 4'hF, 32'h22222222, 0);
    drive(1, 0, 12'h3FF, 4'h0, 32'h0, 0);
    chk("b2b_v0", rvalid, 1);
    chk("b2b_d0", rdata, 32'h11111111);
    drive(1, 0, 12'h400, 4'h0, 32'h0, 0);
    chk("b2b_v1", rvalid, 1);
    chk("b2b_d1", rdata, 32'h22222222);

    drive(1, 0, 12'h3FF, 4'h0, 32'h0, 1);
    chk("clr_wins_rv", rvalid, 0);
    chk("clr_ready", ready, 0);
    wait_ready(n);
    chk("clr_len", n, N);
    drive(1, 0, 12'h3FF, 4'h0, 32'h0, 0);
    chk("clr_d3ff", rdata, 32'h0);
    drive(1, 0, 12'h400, 4'h0, 32'h0, 0);
    chk("clr_d400", rdata, 32'h0);

    rand_phase(3000);

    wait_ready(n);
    drive(1, 1, 12'h7FF, 4'hF, 32'hCAFEF00D, 0);
    drive(1, 0, 12'h7FF, 4'h0, 32'h0, 0);
    chk("pre_abort_d", rdata, 32'hCAFEF00D);
    drive(0, 0, 12'h0, 4'h0, 32'h0, 1);
    repeat (500) @(posedge CLK);
    #2;
    rst_n = 1'b0;
    @(posedge CLK);
    #2;
    rst_n = 1'b1;
    chk("abort_rdata", rdata, 32'h0);
    wait_ready(n);
    chk("abort_clear_len", n, N);
    drive(1, 0, 12'h7FF, 4'h0, 32'h0, 0);
    chk("abort_rd_v", rvalid, 1);
    chk("abort_rd_d", rdata, 32'h0);

    rand_phase(2000);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_banked_be.md
# ram_banked_be

Parametrised, banked, single-port synchronous data RAM for the MIPS32 datapath. It is the next generation of the 4K×32 chip-select RAM: depth, width and bank count are generic, writes take per-byte lane enables for sb/sh/sw, and reads are registered with a valid strobe. A sequenced clear engine replaces the old single-cycle clear.

## Interface
- ADDR_WIDTH, 12, word-address width; total depth 2^ADDR_WIDTH words
- DATA_WIDTH, 32, word width; multiple of 8
- BANK_COUNT, 4, number of banks; power of 2, ≤ 2^ADDR_WIDTH
- INIT_CLEAR, 1, 1 = run a full clear automatically after reset release

Ports:
- CLK  in  1  clock; all logic is on posedge
- Rst  in  1  asynchronous, active-low reset
- Req  in  1  access request
- We  in  1  1 = write, 0 = read
- Addr  in  ADDR_WIDTH  word address; top log2(BANK_COUNT) bits select the bank
- BE  in  DATA_WIDTH/8  byte-lane write enables; BE[0] controls WData[7:0]
- WData  in  DATA_WIDTH  write data
- Clr  in  1  synchronous clear request
- Ready  out  1  request can be accepted this cycle
- RValid  out  1  RData valid; one-cycle pulse
- RData  out  DATA_WIDTH  read data

## Operation
- States: CLEAR, IDLE.
- Reset (Rst low) forces state to CLEAR if INIT_CLEAR=1, otherwise to IDLE. It also sets the clear counter to 0, RValid to 0 and RData to 0.
- Reset does not touch the memory arrays.
- Ready = (state==IDLE) && !Clr. This is combinational from state and Clr.
- Accept: Req && Ready on a posedge.
- Accepted write: in the addressed bank, lanes with BE set take WData; other lanes keep their value. BE=0 is a legal no-op.
- Accepted read: RData takes the word; RValid=1 for exactly the next cycle.
- RData holds its last value when RValid=0.
- One request can be accepted per cycle; back-to-back reads give back-to-back RValid.
- In IDLE, Clr=1 moves the state to CLEAR. Clr wins over a simultaneous Req, and that request is not accepted.
- CLEAR: on each cycle, all banks write 0 at bank-local index cnt in parallel, then cnt increments.
  - When cnt = 2^ADDR_WIDTH/BANK_COUNT − 1, that final row is written, cnt returns to 0 and the state returns to IDLE.
  - Req is ignored in CLEAR. Clr in CLEAR has no effect and does not restart the count.
- Reset during CLEAR aborts the clear. If INIT_CLEAR=1, the clear restarts from index 0 after release.

## Timing
- Read latency: 1 cycle, from accepting edge to RValid/RData.
- Write is visible to a read accepted on the following cycle.
- Clear duration: N = 2^ADDR_WIDTH/BANK_COUNT cycles; 1024 at the default parameters.
- After reset release with INIT_CLEAR=1, Ready is low for N cycles and rises on the cycle after the last clear write.
- RValid is never asserted while the block is in CLEAR. A read accepted in the final IDLE cycle before a Clr still completes normally.
- Bank select for the read mux is registered alongside the request, so a bank change between consecutive reads has no bubble.

## Structure
- Shared package ram_pkg holds:
  - state enum {CLEAR, IDLE}
  - a clog2 helper
  - derived constants BANK_BITS = clog2(BANK_COUNT), LOCAL_WIDTH = ADDR_WIDTH − BANK_BITS, LANES = DATA_WIDTH/8
- Sub-module ram_bank: one 2^LOCAL_WIDTH × DATA_WIDTH array with byte-enable write and synchronous read, no reset on the array. It is instantiated BANK_COUNT times in a generate loop.
- Top level holds:
  - the FSM and clear counter
  - the bank decoder, which drives one-hot bank write enables; during CLEAR all banks are enabled with BE all-ones and data 0
  - the registered bank-select read mux

## Test plan
- Set ADDR_WIDTH=4, BANK_COUNT=4, INIT_CLEAR=1, then release reset → Ready is low for exactly 4 cycles, then high; reading address 0xF returns 0x00000000 with one RValid pulse.
- Write 0xDEADBEEF to 0x005 with BE=4'b1111, then read 0x005 on the next cycle → RData = 0xDEADBEEF, RValid high for 1 cycle.
- Then write 0x0000AA00 with BE=4'b0010 and read back → 0xDEADAAEF. Then write with BE=4'b0000 and read back → still 0xDEADAAEF.
- At default parameters, write 0x11111111 to 0x3FF and 0x22222222 to 0x400, then read both on consecutive cycles → the two RValid pulses are back-to-back and carry 0x11111111 then 0x22222222.
- Assert Clr and a read Req in the same IDLE cycle → the request is not accepted (no RValid); Ready is low for 1024 cycles; afterwards reads of 0x3FF and 0x400 return 0.
- Drop Rst at clear cycle 500 (INIT_CLEAR=1), then release → the clear restarts from 0: Ready is low for a full 1024 cycles and RData reads 0 until the first read completes.
